// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Hazard and forwarding controller for a 5-stage pipeline. Each architectural
//   register has two countdown counters: wex (cycles until an EX-stage consumer
//   may proceed) and wid (cycles until an ID-stage consumer may proceed). An
//   instruction in ID stalls while any source it reads still has a nonzero
//   counter. The unit also provides EX/ID forward selects, a sticky stall
//   watchdog and a saturating stall-cycle counter.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   id_*                     instruction currently in ID (sources, dest, latency)
//   sb_clear                 pipeline flush, kills all in-flight producers
//   ex_rs, ex_rt             source addresses held in ID/EX
//   mem_regwrite, mem_rd     EX/MEM writeback info
//   wb_regwrite, wb_rd       MEM/WB writeback info
//   stall_f, stall_d         hold PC and IF/ID
//   flush_e                  bubble into ID/EX
//   fwd_a_e, fwd_b_e         EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   fwd_a_d, fwd_b_d         ID compare operand from EX/MEM
//   hazard_err               sticky watchdog flag
//   stall_cycles             saturating count of stall cycles
module hazard_scoreboard_unit #(
   parameter int unsigned AW          = 5,
   parameter int unsigned MAX_LAT     = 4,
   parameter int unsigned EARLY_EXTRA = 1,
   parameter int unsigned STALL_TMO   = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs,
   input  logic [AW-1:0]    id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic             id_early,
   input  logic             id_regwrite,
   input  logic [AW-1:0]    id_rd,
   input  logic [2:0]       id_lat,
   input  logic             sb_clear,
   input  logic [AW-1:0]    ex_rs,
   input  logic [AW-1:0]    ex_rt,
   input  logic             mem_regwrite,
   input  logic [AW-1:0]    mem_rd,
   input  logic             wb_regwrite,
   input  logic [AW-1:0]    wb_rd,
   output logic             stall_f,
   output logic             stall_d,
   output logic             flush_e,
   output logic [1:0]       fwd_a_e,
   output logic [1:0]       fwd_b_e,
   output logic             fwd_a_d,
   output logic             fwd_b_d,
   output logic             hazard_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int unsigned NREGS = 2**AW;
   localparam int unsigned LW    = $clog2(MAX_LAT + EARLY_EXTRA + 1);
   localparam int unsigned RW    = $clog2(STALL_TMO + 1);

   logic [LW-1:0]    wex_q [NREGS];
   logic [LW-1:0]    wex_d [NREGS];
   logic [LW-1:0]    wid_q [NREGS];
   logic [LW-1:0]    wid_d [NREGS];
   logic [RW-1:0]    run_q, run_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [LW-1:0]    lat_ex;
   logic [LW-1:0]    lat_id;
   logic             need_rs, need_rt;
   logic             stall;
   logic             issue;

   // Latency clamp; ID consumers wait EARLY_EXTRA cycles longer
   always_comb begin
      lat_ex = LW'(id_lat);
      if (32'(id_lat) > MAX_LAT) begin
         lat_ex = LW'(MAX_LAT);
      end
      lat_id = lat_ex + LW'(EARLY_EXTRA);
   end

   // Source readiness; register 0 is hardwired and never pending
   always_comb begin
      need_rs = 1'b0;
      need_rt = 1'b0;
      if (id_rs != '0) begin
         need_rs = id_early ? (wid_q[id_rs] != '0) : (wex_q[id_rs] != '0);
      end
      if (id_rt != '0) begin
         need_rt = id_early ? (wid_q[id_rt] != '0) : (wex_q[id_rt] != '0);
      end
   end

   // A flush cycle never stalls, and stalled instructions never issue
   assign stall = id_valid & ~sb_clear &
                  ((id_rs_used & need_rs) | (id_rt_used & need_rt));
   assign issue = id_valid & ~stall & ~sb_clear & id_regwrite & (id_rd != '0);

   // Scoreboard next state: decrement, then issue overrides, then flush overrides all
   always_comb begin
      for (int r = 0; r < int'(NREGS); r++) begin
         wex_d[r] = (wex_q[r] != '0) ? wex_q[r] - LW'(1) : wex_q[r];
         wid_d[r] = (wid_q[r] != '0) ? wid_q[r] - LW'(1) : wid_q[r];
      end
      if (issue) begin
         wex_d[id_rd] = lat_ex;
         wid_d[id_rd] = lat_id;
      end
      if (sb_clear) begin
         for (int r = 0; r < int'(NREGS); r++) begin
            wex_d[r] = '0;
            wid_d[r] = '0;
         end
      end
      wex_d[0] = '0;
      wid_d[0] = '0;
   end

   // Watchdog run length and saturating stall counter
   always_comb begin
      run_d = '0;
      err_d = err_q;
      cnt_d = cnt_q;
      if (stall) begin
         run_d = (run_q == RW'(STALL_TMO)) ? run_q : run_q + RW'(1);
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (run_d == RW'(STALL_TMO)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < int'(NREGS); r++) begin
            wex_q[r] <= '0;
            wid_q[r] <= '0;
         end
         run_q <= '0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         for (int r = 0; r < int'(NREGS); r++) begin
            wex_q[r] <= wex_d[r];
            wid_q[r] <= wid_d[r];
         end
         run_q <= run_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   // Forward selects; EX/MEM has priority over MEM/WB
   always_comb begin
      fwd_a_e = 2'b00;
      fwd_b_e = 2'b00;
      fwd_a_d = 1'b0;
      fwd_b_d = 1'b0;
      if (!rst) begin
         if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            fwd_a_e = 2'b10;
         end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            fwd_a_e = 2'b01;
         end
         if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rt)) begin
            fwd_b_e = 2'b10;
         end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rt)) begin
            fwd_b_e = 2'b01;
         end
         fwd_a_d = mem_regwrite && (mem_rd != '0) && (mem_rd == id_rs);
         fwd_b_d = mem_regwrite && (mem_rd != '0) && (mem_rd == id_rt);
      end
   end

   assign stall_f      = stall & ~rst;
   assign stall_d      = stall & ~rst;
   assign flush_e      = stall & ~rst;
   assign hazard_err   = err_q;
   assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_rs_used, id_rt_used, id_early, id_regwrite, sb_clear;
   logic [4:0] id_rs, id_rt, id_rd, ex_rs, ex_rt, mem_rd, wb_rd;
   logic [2:0] id_lat;
   logic       mem_regwrite, wb_regwrite;

   logic        stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, hazard_err;
   logic [1:0]  fwd_a_e, fwd_b_e;
   logic [15:0] stall_cycles;

   logic        w_stall_f, w_stall_d, w_flush_e, w_fwd_a_d, w_fwd_b_d, w_err;
   logic [1:0]  w_fwd_a_e, w_fwd_b_e;
   logic [15:0] w_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_early(id_early),
      .id_regwrite(id_regwrite), .id_rd(id_rd), .id_lat(id_lat), .sb_clear(sb_clear),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .stall_f(stall_f), .stall_d(stall_d),
      .flush_e(flush_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d),
      .fwd_b_d(fwd_b_d), .hazard_err(hazard_err), .stall_cycles(stall_cycles));

   // Long-latency, short-timeout instance for the watchdog sequence
   hazard_scoreboard_unit #(.MAX_LAT(7), .STALL_TMO(8)) dut_wd (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_early(id_early),
      .id_regwrite(id_regwrite), .id_rd(id_rd), .id_lat(id_lat), .sb_clear(sb_clear),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .stall_f(w_stall_f), .stall_d(w_stall_d),
      .flush_e(w_flush_e), .fwd_a_e(w_fwd_a_e), .fwd_b_e(w_fwd_b_e), .fwd_a_d(w_fwd_a_d),
      .fwd_b_d(w_fwd_b_d), .hazard_err(w_err), .stall_cycles(w_cnt));

   typedef struct {
      logic       v, rsu, rtu, early, rw, clr, mrw, wrw;
      logic [4:0] rs, rt, rd, exrs, exrt, mrd, wrd;
      logic [2:0] lat;
      logic       e_stall, e_fad, e_fbd;
      logic [1:0] e_fa, e_fb;
      logic [15:0] e_cnt;
   } vec_t;

   localparam int NV = 39;
   vec_t tbl [NV];

   function automatic vec_t mk(
      input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
      input logic rtu, input logic early, input logic rw, input logic [4:0] rd,
      input logic [2:0] lat, input logic clr, input logic [4:0] exrs,
      input logic [4:0] exrt, input logic mrw, input logic [4:0] mrd, input logic wrw,
      input logic [4:0] wrd, input logic e_stall, input logic [1:0] e_fa,
      input logic [1:0] e_fb, input logic e_fad, input logic e_fbd,
      input logic [15:0] e_cnt);
      vec_t t;
      t.v = v; t.rs = rs; t.rt = rt; t.rsu = rsu; t.rtu = rtu; t.early = early;
      t.rw = rw; t.rd = rd; t.lat = lat; t.clr = clr; t.exrs = exrs; t.exrt = exrt;
      t.mrw = mrw; t.mrd = mrd; t.wrw = wrw; t.wrd = wrd; t.e_stall = e_stall;
      t.e_fa = e_fa; t.e_fb = e_fb; t.e_fad = e_fad; t.e_fbd = e_fbd; t.e_cnt = e_cnt;
      return t;
   endfunction

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t t);
      id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_rs_used = t.rsu; id_rt_used = t.rtu;
      id_early = t.early; id_regwrite = t.rw; id_rd = t.rd; id_lat = t.lat;
      sb_clear = t.clr; ex_rs = t.exrs; ex_rt = t.exrt; mem_regwrite = t.mrw;
      mem_rd = t.mrd; wb_regwrite = t.wrw; wb_rd = t.wrd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      apply(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0, 0));
   endtask

   // Producer into rd with latency lat, no sources read
   task automatic produce(input logic [4:0] rd, input logic [2:0] lat);
      apply(mk(1,0,0,0,0,0,1,rd,lat,0, 0,0,0,0,0,0, 0,0,0,0,0, 0));
   endtask

   // Early (ID-stage) consumer of rs
   task automatic consume_early(input logic [4:0] rs);
      apply(mk(1,rs,0,1,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0, 0));
   endtask

   task automatic all_zero(input string tag);
      chk({tag, " stall_f"}, stall_f, 0);   chk({tag, " stall_d"}, stall_d, 0);
      chk({tag, " flush_e"}, flush_e, 0);   chk({tag, " fwd_a_e"}, fwd_a_e, 0);
      chk({tag, " fwd_b_e"}, fwd_b_e, 0);   chk({tag, " fwd_a_d"}, fwd_a_d, 0);
      chk({tag, " fwd_b_d"}, fwd_b_d, 0);   chk({tag, " err"}, hazard_err, 0);
      chk({tag, " cnt"}, stall_cycles, 0);
      chk({tag, " wd stall_d"}, w_stall_d, 0); chk({tag, " wd fwd_a_e"}, w_fwd_a_e, 0);
      chk({tag, " wd err"}, w_err, 0);         chk({tag, " wd cnt"}, w_cnt, 0);
   endtask

   initial begin
      //          v rs rt su tu e rw rd lt c  exs ext mw md ww wd  st fa    fb    fad fbd cnt
      tbl[0]  = mk(0,0, 0, 0,0,0,0, 0, 0,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 0);
      tbl[1]  = mk(1,1, 2, 1,1,0,1, 3, 0,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 0);
      tbl[2]  = mk(1,3, 4, 1,1,1,0, 0, 0,0, 1,  2,  0, 0, 0, 0,  1, 2'b00,2'b00,0,0, 0);
      tbl[3]  = mk(1,3, 4, 1,1,1,0, 0, 0,0, 0,  0,  1, 3, 0, 0,  0, 2'b00,2'b00,1,0, 1);
      tbl[4]  = mk(1,2, 0, 1,0,0,1, 5, 1,0, 3,  4,  0, 0, 1, 3,  0, 2'b01,2'b00,0,0, 1);
      tbl[5]  = mk(1,5, 1, 1,1,0,1, 6, 0,0, 2,  0,  0, 0, 0, 0,  1, 2'b00,2'b00,0,0, 1);
      tbl[6]  = mk(1,5, 1, 1,1,0,1, 6, 0,0, 0,  0,  1, 5, 0, 0,  0, 2'b00,2'b00,1,0, 2);
      tbl[7]  = mk(0,0, 0, 0,0,0,0, 0, 0,0, 5,  1,  0, 0, 1, 5,  0, 2'b01,2'b00,0,0, 2);
      tbl[8]  = mk(1,1, 2, 1,1,0,1, 7, 4,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 2);
      for (int k = 0; k < 5; k++)
         tbl[9+k] = mk(1,7,0,1,0,1,0,0,0,0, 0,0,0,0,0,0, 1,2'b00,2'b00,0,0, 16'(2+k));
      tbl[14] = mk(1,7, 0, 1,0,1,0, 0, 0,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 7);
      tbl[15] = mk(0,0, 0, 0,0,0,0, 0, 0,0, 9,  9,  1, 9, 1, 9,  0, 2'b10,2'b10,0,0, 7);
      tbl[16] = mk(1,0, 0, 1,1,1,1, 0, 4,0, 9,  4,  1, 0, 1, 0,  0, 2'b00,2'b00,0,0, 7);
      tbl[17] = mk(1,9, 4, 1,1,1,0, 0, 0,0, 9,  4,  1, 9, 1, 4,  0, 2'b10,2'b01,1,0, 7);
      tbl[18] = mk(0,4, 0, 0,0,0,0, 0, 0,0, 4,  0,  0, 4, 0, 4,  0, 2'b00,2'b00,0,0, 7);
      tbl[19] = mk(1,0, 0, 0,0,0,1, 8, 0,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 7);
      tbl[20] = mk(1,8, 0, 1,0,0,0, 0, 0,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 7);
      tbl[21] = mk(1,0, 0, 0,0,0,1,10, 7,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 7);
      for (int k = 0; k < 4; k++)
         tbl[22+k] = mk(1,0,10,1,1,0,0,0,0,0, 0,0,0,0,0,0, 1,2'b00,2'b00,0,0, 16'(7+k));
      tbl[26] = mk(1,0,10, 1,1,0,0, 0, 0,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 11);
      tbl[27] = mk(1,0, 0, 0,0,0,1,11, 1,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 11);
      tbl[28] = mk(1,11,0, 1,0,0,1,12, 4,0, 0,  0,  0, 0, 0, 0,  1, 2'b00,2'b00,0,0, 11);
      tbl[29] = mk(0,0, 0, 0,0,0,0, 0, 0,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 12);
      tbl[30] = mk(1,12,0, 1,0,0,0, 0, 0,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 12);
      tbl[31] = mk(1,0, 0, 0,0,0,1,13, 4,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 12);
      tbl[32] = mk(1,13,0, 1,0,1,1,14, 4,1, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 12);
      tbl[33] = mk(1,13,14,1,1,1,0, 0, 0,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 12);
      tbl[34] = mk(1,0, 0, 0,0,0,1,15, 4,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 12);
      tbl[35] = mk(1,0, 0, 0,0,0,1,15, 1,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 12);
      tbl[36] = mk(1,15,0, 1,0,1,0, 0, 0,0, 0,  0,  0, 0, 0, 0,  1, 2'b00,2'b00,0,0, 12);
      tbl[37] = mk(1,15,0, 1,0,1,0, 0, 0,0, 0,  0,  0, 0, 0, 0,  1, 2'b00,2'b00,0,0, 13);
      tbl[38] = mk(1,15,0, 1,0,1,0, 0, 0,0, 0,  0,  0, 0, 0, 0,  0, 2'b00,2'b00,0,0, 14);

      // Reset state, with forwarding inputs that would otherwise match
      rst = 1'b1;
      idle();
      mem_regwrite = 1'b1; mem_rd = 5'd3; ex_rs = 5'd3; ex_rt = 5'd3; id_rs = 5'd3;
      step();
      step();
      all_zero("reset");
      rst = 1'b0;
      idle();

      for (int i = 0; i < NV; i++) begin
         apply(tbl[i]);
         #2;
         chk($sformatf("row%0d stall_f", i), stall_f, tbl[i].e_stall);
         chk($sformatf("row%0d stall_d", i), stall_d, tbl[i].e_stall);
         chk($sformatf("row%0d flush_e", i), flush_e, tbl[i].e_stall);
         chk($sformatf("row%0d fwd_a_e", i), fwd_a_e, tbl[i].e_fa);
         chk($sformatf("row%0d fwd_b_e", i), fwd_b_e, tbl[i].e_fb);
         chk($sformatf("row%0d fwd_a_d", i), fwd_a_d, tbl[i].e_fad);
         chk($sformatf("row%0d fwd_b_d", i), fwd_b_d, tbl[i].e_fbd);
         chk($sformatf("row%0d stall_cycles", i), stall_cycles, tbl[i].e_cnt);
         chk($sformatf("row%0d hazard_err", i), hazard_err, 0);
         step();
      end

      // Watchdog: lat-7 producer gives 8 early-consumer stall cycles on dut_wd
      rst = 1'b1;
      idle();
      step();
      rst = 1'b0;
      produce(5'd7, 3'd7);
      #2;
      chk("wd producer stall", w_stall_d, 0);
      step();
      consume_early(5'd7);
      for (int k = 1; k <= 8; k++) begin
         #2;
         chk($sformatf("wd stall%0d stall_d", k), w_stall_d, 1);
         chk($sformatf("wd stall%0d err", k), w_err, 0);
         chk($sformatf("wd stall%0d cnt", k), w_cnt, 32'(k - 1));
         step();
      end
      #2;
      chk("wd release stall_d", w_stall_d, 0);
      chk("wd timeout err", w_err, 1);
      chk("wd stall count", w_cnt, 8);
      chk("clamped stall count", stall_cycles, 5);
      chk("long timeout err", hazard_err, 0);
      step();
      idle();
      #2;
      chk("wd err sticky", w_err, 1);
      step();

      // Asynchronous reset in the middle of a stall
      produce(5'd7, 3'd7);
      step();
      consume_early(5'd7);
      step();
      step();
      step();
      mem_regwrite = 1'b1; mem_rd = 5'd7; ex_rs = 5'd7; ex_rt = 5'd7;
      wb_regwrite = 1'b1; wb_rd = 5'd7;
      #2;
      chk("pre-rst wd stall_d", w_stall_d, 1);
      chk("pre-rst fwd_a_e", fwd_a_e, 2'b10);
      chk("pre-rst fwd_a_d", fwd_a_d, 1);
      rst = 1'b1;
      #1;
      all_zero("mid-rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      chk("post-rst stall_d", stall_d, 0);
      chk("post-rst wd stall_d", w_stall_d, 0);
      chk("post-rst wd err", w_err, 0);
      chk("post-rst fwd_a_e", fwd_a_e, 2'b10);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
